imem_loader: RTL and testbench

- Write-side companion to the fetch-stage instruction memory read port.
- Accepts a byte stream over a valid/ready handshake. The stream is a 2-byte little-endian base address followed by program bytes.
- Converts the stream into one-byte-per-cycle writes on the instruction memory write port (wEn/address/data).
- Holds the processor in stall (cpu_hold) while a program is loaded, and reports completion, byte count and load errors.

---
 rtl/imem_loader.sv | 121 ++++++++++++
 tb/tb_imem_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory write port.
// Takes a 2-byte little-endian base address, then writes program bytes one per cycle.
module imem_loader #(
    parameter int MEM_BYTES = 1025,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             mem_wEn,
    output logic [63:0]      mem_addr,
    output logic [7:0]       mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             load_err,
    output logic [CNT_W-1:0] byte_count,
    output logic             cpu_hold
);

    localparam logic [CNT_W-1:0] MEM_LIM = CNT_W'(MEM_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       base_lo;
    logic [CNT_W-1:0] waddr;
    logic [CNT_W-1:0] hdr_addr;
    logic             accept;
    logic             wr_ok;

    assign accept   = in_valid && in_ready;
    assign hdr_addr = CNT_W'({in_data, base_lo});
    assign wr_ok    = accept && (state == S_DATA) && (waddr < MEM_LIM);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        load_err  = 1'b0;
        cpu_hold  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_HDR0;
            end
            S_HDR0: begin
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (accept) state_nxt = in_last ? S_ERR : S_HDR1;
            end
            S_HDR1: begin
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (accept) state_nxt = (in_last || hdr_addr >= MEM_LIM) ? S_ERR : S_DATA;
            end
            S_DATA: begin
                busy     = 1'b1;
                cpu_hold = 1'b1;
                // An out-of-range byte is dropped before any last-byte handling.
                if (accept) begin
                    if (waddr >= MEM_LIM) state_nxt = S_ERR;
                    else if (in_last)     state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                load_err = 1'b1;
                cpu_hold = 1'b1;
                if (start) state_nxt = S_HDR0;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready   <= 1'b0;
            mem_wEn    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            byte_count <= '0;
            waddr      <= '0;
            base_lo    <= '0;
        end else begin
            in_ready <= (state_nxt == S_HDR0) || (state_nxt == S_HDR1) || (state_nxt == S_DATA);
            mem_wEn  <= wr_ok;
            if (start && (state == S_IDLE || state == S_ERR))
                byte_count <= '0;
            if (accept && state == S_HDR0)
                base_lo <= in_data;
            if (accept && state == S_HDR1)
                waddr <= hdr_addr;
            // Write port is registered: byte accepted at one edge commits at the next.
            if (wr_ok) begin
                mem_addr   <= 64'(waddr);
                mem_wdata  <= in_data;
                waddr      <= waddr + 1'b1;
                byte_count <= byte_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized bench for imem_loader with a queue-based write log
// compared against an address-range model of each load.
module tb_imem_loader;
    localparam int MEM_BYTES = 1025;
    localparam int CNT_W     = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic             mem_wEn;
    logic [63:0]      mem_addr;
    logic [7:0]       mem_wdata;
    logic             busy;
    logic             done;
    logic             load_err;
    logic [CNT_W-1:0] byte_count;
    logic             cpu_hold;

    imem_loader #(.MEM_BYTES(MEM_BYTES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .mem_wEn(mem_wEn), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .load_err(load_err),
        .byte_count(byte_count), .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    logic        hold_at_done = 1'b1;
    logic [63:0] wa[$];
    logic [7:0]  wd[$];
    int          wc[$];
    logic [7:0]  prog[64];

    // Write port monitor: a write commits at the edge following a cycle with mem_wEn high.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mem_wEn === 1'b1) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            wc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            hold_at_done = cpu_hold;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
        done_cnt = 0;
        done_cyc = -1;
        hold_at_done = 1'b1;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    function automatic int exp_count(input int base, input int n);
        if (base >= MEM_BYTES) return 0;
        return (base + n <= MEM_BYTES) ? n : MEM_BYTES - base;
    endfunction

    function automatic bit exp_error(input int base, input int n);
        return (base >= MEM_BYTES) || (base + n > MEM_BYTES);
    endfunction

    // gap < 0 selects a random 0..2 idle cycles before each data byte.
    task automatic run_load(input int base, input int n, input int gap, input bit poke_start);
        int en;
        bit ee;
        int g;
        int lag;
        logic [15:0] b16;
        clear_log();
        b16 = 16'(base);
        do_start();
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("err_cleared", 64'(load_err), 64'd0);
        chk("count_cleared", 64'(byte_count), 64'd0);
        send(b16[7:0], 1'b0);
        send(b16[15:8], 1'b0);
        if (base >= MEM_BYTES) begin
            chk("hdr_reject_ready", 64'(in_ready), 64'd0);
        end else begin
            for (int i = 0; i < n; i++) begin
                if (base + i > MEM_BYTES) break;
                g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
                repeat (g) @(negedge clk);
                if (poke_start && i == 2) start = 1'b1;
                send(prog[i], i == n - 1);
                start = 1'b0;
            end
        end
        repeat (4) @(negedge clk);
        en = exp_count(base, n);
        ee = exp_error(base, n);
        chk("nwrites", 64'(wa.size()), 64'(en));
        for (int i = 0; i < wa.size() && i < en; i++) begin
            chk("waddr", wa[i], 64'(base + i));
            chk("wdata", 64'(wd[i]), 64'(prog[i]));
        end
        chk("byte_count", 64'(byte_count), 64'(en));
        chk("load_err", 64'(load_err), 64'(ee));
        chk("done_cnt", 64'(done_cnt), ee ? 64'd0 : 64'd1);
        chk("cpu_hold_end", 64'(cpu_hold), 64'(ee));
        chk("busy_end", 64'(busy), 64'd0);
        if (!ee && wc.size() > 0) begin
            lag = done_cyc - wc[wc.size()-1];
            chk("hold_at_done", 64'(hold_at_done), 64'd0);
            chk("done_lag_ok", 64'(lag == 0 || lag == 1), 64'd1);
            if (gap == 0)
                chk("contiguous", 64'(wc[wc.size()-1] - wc[0]), 64'(en - 1));
        end
    endtask

    initial begin
        int base;
        int n;
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_wEn", 64'(mem_wEn), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(load_err), 64'd0);
        chk("rst_hold", 64'(cpu_hold), 64'd0);
        chk("rst_addr", mem_addr, 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_count", 64'(byte_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Normal 42-byte load at address 0, no gaps
        for (int i = 0; i < 64; i++) prog[i] = 8'($urandom);
        prog[0] = 8'h30; prog[1] = 8'hF4; prog[2] = 8'h0E;
        run_load(0, 42, 0, 1'b0);

        // Backpressure with valid pattern 1,0,0,1 and a start pulse while busy
        for (int i = 0; i < 5; i++) prog[i] = 8'hA1 + 8'(i);
        run_load(16'h0010, 5, 2, 1'b1);

        // Boundary at the top of memory
        prog[0] = 8'h11; prog[1] = 8'h22; prog[2] = 8'h33;
        run_load(16'h03FF, 3, 0, 1'b0);

        // Bad header, then a clean load out of ERR
        run_load(16'h0401, 4, 0, 1'b0);
        for (int i = 0; i < 64; i++) prog[i] = 8'($urandom);
        run_load(16'h0200, 6, 0, 1'b0);

        // Truncated header
        clear_log();
        do_start();
        send(8'h05, 1'b1);
        chk("trunc_ready", 64'(in_ready), 64'd0);
        chk("trunc_err", 64'(load_err), 64'd1);
        chk("trunc_hold", 64'(cpu_hold), 64'd1);
        repeat (3) @(negedge clk);
        chk("trunc_nwrites", 64'(wa.size()), 64'd0);

        // Reset after 3 of 10 data bytes
        clear_log();
        do_start();
        send(8'h00, 1'b0);
        send(8'h01, 1'b0);
        for (int i = 0; i < 3; i++) send(prog[i], 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_wEn", 64'(mem_wEn), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_err", 64'(load_err), 64'd0);
        chk("mid_rst_hold", 64'(cpu_hold), 64'd0);
        chk("mid_rst_addr", mem_addr, 64'd0);
        chk("mid_rst_count", 64'(byte_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_nwrites", 64'(wa.size()), 64'd3);
        if (wa.size() > 0) chk("mid_rst_last_addr", wa[wa.size()-1], 64'h0102);
        run_load(16'h0100, 10, -1, 1'b0);

        // Randomized loads, some crossing the top of memory
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 64; i++) prog[i] = 8'($urandom);
            base = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 1000))
                                              : MEM_BYTES - int'($urandom_range(1, 8));
            n = int'($urandom_range(1, 20));
            run_load(base, n, -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
